// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the elastic skid stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    function automatic logic [OCC_W-1:0] occ_of(input skid_state_t s);
        logic [OCC_W-1:0] n;
        case (s)
            SKID_BUSY: n = 2'd1;
            SKID_FULL: n = 2'd2;
            default:   n = 2'd0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg_if
// Description : Valid/ready handshake bundle around one elastic skid stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_skid_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) ();

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [OCC_W-1:0]  occupancy;

    // master drives the stage; slave is the stage itself
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

endinterface
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Two-entry elastic pipeline register with registered ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W     = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    pipe_skid_reg_if.slave      bus
);

    skid_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, out_valid_q;
    logic [OCC_W-1:0]  occ_q;

    logic w_push;
    logic w_pop;

    assign w_push = bus.in_valid & in_ready_q;
    assign w_pop  = out_valid_q & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            // a pop this cycle already completed; any push is dropped
            state_d = SKID_EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (w_push) begin
                        state_d = SKID_BUSY;
                        main_d  = bus.in_data;
                    end
                end
                SKID_BUSY: begin
                    if (w_push && w_pop) begin
                        main_d = bus.in_data;
                    end else if (w_push) begin
                        state_d = SKID_FULL;
                        skid_d  = bus.in_data;
                    end else if (w_pop) begin
                        state_d = SKID_EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                SKID_FULL: begin
                    if (w_pop) begin
                        state_d = SKID_BUSY;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = SKID_EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= SKID_EMPTY;
            main_q      <= BUBBLE_VAL;
            skid_q      <= BUBBLE_VAL;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != SKID_FULL);
            out_valid_q <= (state_d != SKID_EMPTY);
            occ_q       <= occ_of(state_d);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.occupancy = occ_q;

endmodule
`default_nettype wire
